// File: rtl/quad_gray_if.sv
// quad_gray_if: encoder inputs, clear and decoded position outputs of quad_gray_decoder
// master: drives enc_a/enc_b/clr and observes results; slave: the decoder
interface quad_gray_if #(parameter int BITS = 8);
    logic            enc_a;
    logic            enc_b;
    logic            clr;
    logic [BITS-1:0] pos;
    logic [BITS-1:0] pos_gray;
    logic            step;
    logic            dir;
    logic            err;
    modport master (output enc_a, enc_b, clr, input pos, pos_gray, step, dir, err);
    modport slave  (input enc_a, enc_b, clr, output pos, pos_gray, step, dir, err);
endinterface

// File: rtl/quad_gray_decoder.sv
// quad_gray_decoder: debounced quadrature decoder with binary and Gray-coded position
// clk, rst         : clock, asynchronous active-high reset
// bus.enc_a/enc_b  : raw quadrature channels (asynchronous, may bounce)
// bus.clr          : synchronous clear of pos and err
// bus.pos/pos_gray : step count modulo 2^BITS and its Gray code
// bus.step/dir/err : one-cycle step pulse, last direction (1 = up), sticky illegal-transition flag
module quad_gray_decoder #(
    parameter int BITS       = 8,
    parameter int DEB_CYCLES = 16
) (
    input logic      clk,
    input logic      rst,
    quad_gray_if.slave bus
);
    logic [1:0]      s1, s2, acc, prev, fill, idx_c, idx_p, d;
    logic [15:0]     cnt [2];
    logic            primed, settled, up, dn, bad;
    logic [BITS-1:0] pos;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            fill <= '0;
        end else begin
            s1   <= {bus.enc_a, bus.enc_b};
            s2   <= s1;
            fill <= {fill[0], 1'b1};
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == acc[i]) cnt[i] <= '0;
                else if (cnt[i] == 16'(DEB_CYCLES - 1)) begin
                    acc[i] <= ~acc[i];
                    cnt[i] <= '0;
                end else cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end
    // Map the Gray pair {A,B} to a position 0..3 so the step is a modulo-4 difference:
    // 1 = up, 3 = down, 2 = both bits flipped (illegal).
    assign idx_c = {acc[1], acc[1] ^ acc[0]};
    assign idx_p = {prev[1], prev[1] ^ prev[0]};
    assign d     = idx_c - idx_p;
    assign up    = primed && d == 2'd1;
    assign dn    = primed && d == 2'd3;
    assign bad   = primed && d == 2'd2;
    // Priming waits until the synchronizers hold real input samples and both accepted
    // levels agree with them, so an encoder parked away from 00 during reset is adopted
    // as the starting pair instead of being decoded as a 00->11 error.
    assign settled = fill[1] && s2 == acc;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            primed  <= 1'b0;
            pos     <= '0;
            bus.step <= 1'b0;
            bus.dir  <= 1'b0;
            bus.err  <= 1'b0;
        end else begin
            prev     <= acc;
            primed   <= primed || settled;
            bus.step <= !bus.clr && (up || dn);
            if (bus.clr) begin
                pos     <= '0;
                bus.err <= 1'b0;
            end else begin
                if (up || dn) begin
                    pos     <= up ? pos + BITS'(1) : pos - BITS'(1);
                    bus.dir <= up;
                end
                if (bad) bus.err <= 1'b1;
            end
        end
    end
    assign bus.pos      = pos;
    assign bus.pos_gray = pos ^ (pos >> 1);
endmodule

// File: tb/tb_quad_gray_decoder.sv
// tb_quad_gray_decoder: directed scoreboard bench for quad_gray_decoder (BITS=8, DEB_CYCLES=4)
module tb_quad_gray_decoder;
    typedef struct {
        logic [7:0] pos;
        logic [7:0] gray;
        logic       dir;
        int         cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];
    quad_gray_if #(.BITS(8)) bus ();
    quad_gray_decoder #(.BITS(8), .DEB_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Step latency is 2 sync + 4 debounce + 1 decode = 7 cycles from the driving negedge.
    task automatic drive(input logic a, input logic b, input int hold, input logic exp_step,
                         input logic [7:0] ep, input logic [7:0] eg, input logic ed);
        exp_t e;
        bus.enc_a = a;
        bus.enc_b = b;
        if (exp_step) begin
            e.pos = ep; e.gray = eg; e.dir = ed; e.cyc = cyc + 7;
            q.push_back(e);
        end
        repeat (hold) @(negedge clk);
    endtask
    task automatic pulse_clr();
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask
    always @(negedge clk) begin
        if (!rst && bus.step === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_step: step=1 with pos=%0d, expected no step (cycle %0d)", bus.pos, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("step_pos", int'(bus.pos), int'(e.pos));
                chk("step_gray", int'(bus.pos_gray), int'(e.gray));
                chk("step_dir", int'(bus.dir), int'(e.dir));
                chk("step_cycle", cyc, e.cyc);
            end
        end
    end
    initial begin
        rst = 1'b1;
        bus.enc_a = 1'b0;
        bus.enc_b = 1'b0;
        bus.clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pos", int'(bus.pos), 0);
        chk("rst_gray", int'(bus.pos_gray), 0);
        chk("rst_step", int'(bus.step), 0);
        chk("rst_dir", int'(bus.dir), 0);
        chk("rst_err", int'(bus.err), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        // four clean up-steps
        drive(0, 1, 10, 1, 8'd1, 8'd1, 1);
        drive(1, 1, 10, 1, 8'd2, 8'd3, 1);
        drive(1, 0, 10, 1, 8'd3, 8'd2, 1);
        drive(0, 0, 10, 1, 8'd4, 8'd6, 1);
        chk("up_pos", int'(bus.pos), 4);
        chk("up_gray", int'(bus.pos_gray), 6);
        chk("up_dir", int'(bus.dir), 1);
        chk("up_err", int'(bus.err), 0);
        // 3-cycle glitch is filtered; 6-cycle glitch is accepted (down), and its release
        // is itself a clean edge that steps back up
        drive(1, 0, 3, 0, 8'd0, 8'd0, 0);
        drive(0, 0, 10, 0, 8'd0, 8'd0, 0);
        chk("glitch3_pos", int'(bus.pos), 4);
        drive(1, 0, 6, 1, 8'd3, 8'd2, 0);
        drive(0, 0, 12, 1, 8'd4, 8'd6, 1);
        chk("glitch6_pos", int'(bus.pos), 4);
        // wrap below zero and back
        pulse_clr();
        chk("clr_pos", int'(bus.pos), 0);
        drive(1, 0, 10, 1, 8'd255, 8'd128, 0);
        chk("wrap_pos", int'(bus.pos), 255);
        chk("wrap_gray", int'(bus.pos_gray), 128);
        chk("wrap_dir", int'(bus.dir), 0);
        drive(0, 0, 10, 1, 8'd0, 8'd0, 1);
        chk("unwrap_pos", int'(bus.pos), 0);
        // both channels flip together: illegal
        drive(1, 1, 12, 0, 8'd0, 8'd0, 0);
        chk("illegal_err", int'(bus.err), 1);
        chk("illegal_pos", int'(bus.pos), 0);
        chk("illegal_dir", int'(bus.dir), 1);
        pulse_clr();
        chk("clr_err", int'(bus.err), 0);
        chk("clr_err_pos", int'(bus.pos), 0);
        drive(1, 0, 10, 1, 8'd1, 8'd1, 1);
        drive(0, 0, 10, 1, 8'd2, 8'd3, 1);
        // clr lands on the decode edge of a down-step: step discarded, dir kept
        drive(1, 0, 6, 0, 8'd0, 8'd0, 0);
        pulse_clr();
        chk("clrstep_pos", int'(bus.pos), 0);
        chk("clrstep_dir", int'(bus.dir), 1);
        chk("clrstep_step", int'(bus.step), 0);
        repeat (5) @(negedge clk);
        chk("clrstep_pos_late", int'(bus.pos), 0);
        // reset mid-debounce with the encoder left at 11 through reset
        drive(1, 1, 4, 0, 8'd0, 8'd0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_pos", int'(bus.pos), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("prime_err", int'(bus.err), 0);
        chk("prime_pos", int'(bus.pos), 0);
        chk("prime_dir", int'(bus.dir), 0);
        drive(1, 0, 10, 1, 8'd1, 8'd1, 1);
        chk("prime_next_pos", int'(bus.pos), 1);
        repeat (5) @(negedge clk);
        chk("missing_steps", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/quad_gray_decoder.md
QUAD_GRAY_DECODER -- requirements
Module: quad_gray_decoder

Interface
- REQ-001 Parameter BITS, default 8: width of the position counter and its Gray-coded copy.
- REQ-002 Parameter DEB_CYCLES, default 16: consecutive stable cycles required to accept an input level; legal range 1..65535.
- REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004 rst  input  1  asynchronous, active-high reset.
- REQ-005 enc_a  input  1  quadrature channel A; asynchronous to clk; may bounce.
- REQ-006 enc_b  input  1  quadrature channel B; asynchronous to clk; may bounce.
- REQ-007 clr  input  1  synchronous clear of position and error flag.
- REQ-008 pos  output  BITS  signed-agnostic step count, modulo 2^BITS.
- REQ-009 pos_gray  output  BITS  Gray code of pos (pos XOR pos>>1), same cycle as pos.
- REQ-010 step  output  1  one-cycle pulse per accepted step.
- REQ-011 dir  output  1  direction of the most recent step: 1 = up, 0 = down.
- REQ-012 err  output  1  sticky flag: illegal two-bit transition detected.

Function
- REQ-013 Each of enc_a, enc_b SHALL pass through a two-flop synchronizer before any other logic.
- REQ-014 Per channel, a debounce counter SHALL count cycles in which the synchronized level differs from that channel's accepted level; any cycle of agreement SHALL zero the counter.
- REQ-015 When a channel's counter reaches DEB_CYCLES, its accepted level SHALL toggle and the counter SHALL zero in the same cycle.
- REQ-016 Both channels SHALL debounce independently; both accepted levels may change in the same cycle.
- REQ-017 Decoder SHALL compare the current accepted pair {A,B} with the registered previous pair every cycle; the previous pair SHALL update to the current pair every cycle.
- REQ-018 Sequence 00->01->11->10->00 SHALL count up (pos+1, dir=1); the reverse sequence SHALL count down (pos-1, dir=0).
- REQ-019 No change in the pair SHALL produce no step and leave pos, dir unchanged.
- REQ-020 A change of both bits in one cycle SHALL set err, produce no step, and leave pos, dir unchanged.
- REQ-021 step SHALL assert in the cycle after the accepted pair changes legally, coincident with the updated pos and dir; pulse width exactly one cycle.
- REQ-022 Latency from a clean input edge to step SHALL be 2 (sync) + DEB_CYCLES + 1 cycles.
- REQ-023 pos SHALL wrap: all-ones +1 -> 0; 0 -1 -> all-ones.
- REQ-024 clr asserted SHALL set pos=0 and err=0 in the next cycle; a simultaneous step is discarded (step=0, dir unchanged); clr has priority over err set in the same cycle.
- REQ-025 A priming flag SHALL be clear after reset; the first cycle after reset in which the accepted pair is evaluated SHALL load the previous pair without counting or flagging, then set the flag.
- REQ-026 Debouncing and synchronization SHALL continue while clr is asserted.

Reset
- REQ-027 rst SHALL asynchronously force: synchronizer flops 0, accepted levels 0, debounce counters 0, previous pair 00, priming flag clear, pos 0, pos_gray 0, step 0, dir 0, err 0.
- REQ-028 rst asserted mid-step or mid-debounce SHALL discard all partial progress; no step pulse SHALL follow rst deassertion for a change begun before reset.
- REQ-029 After rst deassertion, operation SHALL resume on the first rising clk edge.

Verification
- REQ-030 DEB_CYCLES=4, four clean up-steps (00,01,11,10,00), each held 10 cycles -> four step pulses, pos=4, pos_gray=6, dir=1, err=0; each step 7 cycles after its edge.
- REQ-031 enc_a glitches high for 3 cycles with DEB_CYCLES=4 -> no step, pos unchanged; glitch of 6 cycles -> exactly one step.
- REQ-032 From pos=0, one down-step (00->10) -> pos=all-ones (255 for BITS=8), pos_gray=128, dir=0; then up-step -> pos=0.
- REQ-033 enc_a and enc_b toggle on the same clk edge from 00 to 11 -> err=1, no step, pos unchanged; then clr for 1 cycle -> err=0, pos=0.
- REQ-034 clr asserted in the cycle a legal step is decoded -> pos=0, step=0, dir unchanged.
- REQ-035 Encoder held at 11 through reset, rst released -> no step, err=0 after priming; next legal transition 11->10 -> pos=1.
